icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
Miss-handling stage directly upstream of the instruction cache's line-fill input. It watches the fetch address and the cache hit flag. On a miss it reads the missing 16-byte line from word-wide instruction memory as 4 sequential beats and assembles the 128-bit line. It then presents the line to the cache for one cycle and stalls the fetch stage until the refill completes.

Parameters:
WORD_W, 32, memory beat width in bits.
LINE_WORDS, 4, words per cache line. Fixed at 4 to match the cache's 2-bit word offset; any other value is a configuration error.
CNT_W, 16, width of the refill performance counter.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
fetch_addr  in  32  current fetch byte address (same value driven to the cache Address)
req_valid  in  1  fetch stage wants an instruction this cycle
hit  in  1  cache hit flag, registered by the cache
mem_rd  out  1  word read request to instruction memory
mem_addr  out  32  word address of the current beat: line base + 4*beat
mem_ready  in  1  memory returns mem_rdata for the current beat this cycle
mem_rdata  in  32  read data for the current beat
data_line  out  128  assembled line for the cache's DataLine input
line_valid  out  1  one-cycle strobe: data_line is complete
stall  out  1  freeze the PC / fetch stage
misalign_err  out  1  fetch_addr[1:0] != 0 while a request is pending
refill_count  out  CNT_W  number of completed refills, saturating

Behaviour:
- Reset (async, takes effect immediately): state=IDLE, mem_rd=0, mem_addr=0, data_line=0, line_valid=0, stall=0, misalign_err=0, refill_count=0, beat counter=0, line buffer=0.
- States: IDLE, FETCH, DONE.
- IDLE:
  - misalign_err = req_valid & (fetch_addr[1:0]!=0), combinational. A misaligned request never starts a refill and does not assert stall.
  - miss = req_valid & !hit & fetch_addr[1:0]==0. On a miss: latch base = {fetch_addr[31:4],4'b0}, clear the beat counter, go to FETCH.
  - stall = miss, combinational, so the PC freezes in the same cycle the miss is seen.
- FETCH:
  - mem_rd=1; mem_addr = base + {beat,2'b00}.
  - Each cycle with mem_ready=1: write mem_rdata into buffer[32*beat+31 : 32*beat] and increment beat. Word 0 lands in data_line[31:0], matching cache offset 0.
  - When mem_ready arrives with beat==3, go to DONE. mem_ready=0 holds the state, the address and mem_rd (no timeout).
  - stall=1.
- DONE (exactly 1 cycle):
  - data_line = buffer, line_valid=1, mem_rd=0, stall=1.
  - Increment refill_count unless it equals all-ones; then return to IDLE.
- Outside DONE: data_line holds its last value and line_valid=0. The cache captures the line only on the line_valid cycle.
- Latency:
  - Miss detected in cycle T; earliest line_valid at T+5 with mem_ready tied high (4 beats + DONE).
  - First cycle back in IDLE is T+6. The cache sees its hit on the following clk edge, so stall stays asserted via miss until hit=1.
- Line ownership:
  - base is frozen for the whole refill. Changes on fetch_addr or req_valid during FETCH/DONE are ignored.
  - A redirect mid-refill does not abort: the line completes and is delivered, and the new address is evaluated in IDLE.
- Simultaneous events:
  - rst with mem_ready: rst wins and the beat is discarded.
  - rst in FETCH/DONE: immediate IDLE, no line_valid, counter reset.
- Base addresses only cover bits [31:4]. mem_addr wraps naturally within 32 bits and never crosses the line (beat ≤ 3).

Decomposition:
- Shared package: state encoding constants (IDLE/FETCH/DONE), LINE_WORDS, LINE_W=128, OFFSET_LSB=2 / INDEX_LSB=4 address field positions, so the cache and this block use identical field boundaries.
- One natural sub-module: line_assembler (beat counter + 128-bit shift/indexed buffer, with load, clear and full outputs). The FSM, stall logic and counter stay in the top.

Test Plan:
1. Reset: assert rst mid-FETCH after 2 beats -> immediately all outputs 0, state IDLE; no line_valid after release.
2. Cold miss: fetch_addr=0x0000_0044, req_valid=1, hit=0, mem_ready=1, memory word n = 0xA000_0000+n -> mem_addr sequence 0x40,0x44,0x48,0x4C. line_valid at T+5 with data_line=0xA000_0013_A000_0012_A000_0011_A000_0010; refill_count=1.
3. Hit: hit=1, fetch_addr=0x80 -> mem_rd never asserts, stall=0, refill_count unchanged.
4. Wait states: mem_ready low for 3 cycles before beat 2 -> mem_addr holds base+8, mem_rd=1, stall=1 throughout. line_valid 3 cycles later than in scenario 2, data unchanged.
5. Redirect mid-refill: fetch_addr changes 0x100→0x200 during beat 1 -> all 4 beats still target 0x100–0x10C. The line is delivered, then a new refill at 0x200 starts if hit=0.
6. Misaligned/saturation: fetch_addr=0x102, req_valid=1 -> misalign_err=1, stall=0, no mem_rd. With CNT_W=2 forced, 5 refills -> refill_count stays 3.

Source files
------------

// File: rtl/icache_refill_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl_pkg
//
// Shared definitions for the instruction-cache refill path. The cache and the
// refill controller both import this package so that they agree on where the
// word offset and the line index start inside a fetch address.
//
// Contents:
//   LINE_WORDS   words per cache line (the cache has a 2-bit word offset)
//   WORD_BYTES   bytes per memory beat
//   LINE_W       bits per cache line
//   OFFSET_LSB   lowest bit of the word offset   (fetch_addr[3:2])
//   INDEX_LSB    lowest bit above the line offset (fetch_addr[31:4] = line)
//   BEAT_W       width of the beat counter
//   refill_state_e  IDLE / FETCH / DONE state encoding
//   line_base()     line-aligned base address of a byte address
//   is_misaligned() true when a byte address is not word aligned
// -----------------------------------------------------------------------------
package icache_refill_ctrl_pkg;

    localparam int LINE_WORDS = 4;
    localparam int WORD_BYTES = 4;
    localparam int LINE_W     = 128;
    localparam int OFFSET_LSB = 2;
    localparam int INDEX_LSB  = 4;
    localparam int BEAT_W     = 2;

    localparam logic [31:0] LINE_MASK = 32'((1 << INDEX_LSB) - 1);
    localparam logic [31:0] WORD_MASK = 32'((1 << OFFSET_LSB) - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } refill_state_e;

    // Clears the byte-within-line bits, giving the address of beat 0.
    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return addr & ~LINE_MASK;
    endfunction

    // Instruction fetches must be word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr & WORD_MASK) != 32'd0;
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_line_assembler.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl_line_assembler
//
// Beat counter plus line buffer. Each load writes wdata into the word slot
// selected by the beat counter and advances the counter; word 0 occupies the
// least significant bits of the line so that it matches cache offset 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (counter and buffer to 0)
//   clear      restart at beat 0 for a new line (buffer contents are kept,
//              every slot is overwritten before the line is used)
//   load       store wdata at the current beat and advance the counter
//   wdata      beat data from memory
//   beat       index of the word the next load will fill
//   full       this load fills the final word: the line is complete
//   line_next  buffer contents including the word being loaded this cycle
// -----------------------------------------------------------------------------
module icache_refill_ctrl_line_assembler
    import icache_refill_ctrl_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int WORDS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [WORD_W-1:0]       wdata,
    output logic [BEAT_W-1:0]       beat,
    output logic                    full,
    output logic [WORD_W*WORDS-1:0] line_next
);

    logic [WORD_W*WORDS-1:0] line_q;
    logic                    last_beat;

    assign last_beat = (beat == BEAT_W'(WORDS - 1));
    assign full      = load && last_beat;

    // Merge the incoming word so the controller can hand the complete line to
    // the cache on the same edge that the last beat arrives.
    always_comb begin
        line_next = line_q;
        for (int w = 0; w < WORDS; w++) begin
            if (beat == BEAT_W'(w)) begin
                line_next[w*WORD_W +: WORD_W] = wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat   <= '0;
            line_q <= '0;
        end else if (clear) begin
            beat <= '0;
        end else if (load) begin
            line_q <= line_next;
            // Wraps back to 0 after the last word; clear also restarts it.
            beat   <= beat + BEAT_W'(1);
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl
//
// Miss handler in front of the instruction cache's line-fill input. On a miss
// of an aligned fetch it reads the 16-byte line from word-wide instruction
// memory in 4 sequential beats, presents the assembled line for one cycle and
// stalls the fetch stage until the refill completes.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   fetch_addr    current fetch byte address (also drives the cache address)
//   req_valid     fetch stage wants an instruction this cycle
//   hit           cache hit flag (registered by the cache)
//   mem_rd        word read request to instruction memory
//   mem_addr      byte address of the current beat: line base + 4*beat
//   mem_ready     memory returns mem_rdata for the current beat this cycle
//   mem_rdata     read data for the current beat
//   data_line     assembled line for the cache's DataLine input
//   line_valid    one-cycle strobe: data_line is complete
//   stall         freeze the PC / fetch stage
//   misalign_err  misaligned fetch request seen while idle
//   refill_count  completed refills, saturating at all-ones
//   dbg_state     current FSM state (refill_state_e encoding)
//
// Handshake: while mem_rd is high, mem_addr is stable and one beat is
// transferred on every cycle in which mem_ready is also high; mem_addr moves
// to the next word on the following cycle. mem_ready low simply holds the
// request (there is no timeout). line_valid has no back-pressure: the cache
// captures data_line on the strobe cycle.
//
// Timing: a miss seen in cycle T gives line_valid at T+5 at the earliest and
// IDLE again at T+6. stall is combinational on the miss in IDLE so the PC
// freezes in the miss cycle, and stays high until the cache reports a hit.
// -----------------------------------------------------------------------------
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       fetch_addr,
    input  logic              req_valid,
    input  logic              hit,
    output logic              mem_rd,
    output logic [31:0]       mem_addr,
    input  logic              mem_ready,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [LINE_W-1:0] data_line,
    output logic              line_valid,
    output logic              stall,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  refill_count,
    output logic [1:0]        dbg_state
);

    // The cache's word offset is 2 bits wide, so the line geometry is fixed.
    if (LINE_WORDS != icache_refill_ctrl_pkg::LINE_WORDS ||
        WORD_W * LINE_WORDS != LINE_W) begin : g_cfg_error
        $error("icache_refill_ctrl: line must be 4 words totalling 128 bits");
    end

    refill_state_e     state;
    logic [31:0]       base;
    logic              misaligned;
    logic              miss;
    logic              beat_load;
    logic [BEAT_W-1:0] beat;
    logic              line_full;
    logic [LINE_W-1:0] line_next;

    assign misaligned = is_misaligned(fetch_addr);

    // Requests are evaluated only in IDLE; anything the fetch stage does during
    // FETCH/DONE is ignored. Reset gates both so every output is 0 while rst is
    // high, even with a request pending.
    assign miss         = !rst && (state == ST_IDLE) && req_valid && !hit && !misaligned;
    assign misalign_err = !rst && (state == ST_IDLE) && req_valid && misaligned;
    assign stall        = miss || (state != ST_IDLE);

    assign beat_load = (state == ST_FETCH) && mem_ready;

    // base is line aligned and beat <= 3, so a refill never leaves its line.
    assign mem_addr = base + {{(32 - BEAT_W - OFFSET_LSB){1'b0}}, beat, {OFFSET_LSB{1'b0}}};

    assign dbg_state = state;

    icache_refill_ctrl_line_assembler #(
        .WORD_W (WORD_W),
        .WORDS  (LINE_WORDS)
    ) u_line_assembler (
        .clk       (clk),
        .rst       (rst),
        .clear     (miss),
        .load      (beat_load),
        .wdata     (mem_rdata),
        .beat      (beat),
        .full      (line_full),
        .line_next (line_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            base         <= '0;
            mem_rd       <= 1'b0;
            data_line    <= '0;
            line_valid   <= 1'b0;
            refill_count <= '0;
        end else begin
            line_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (miss) begin
                        base   <= line_base(fetch_addr);
                        mem_rd <= 1'b1;
                        state  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // Last beat accepted: publish the line for exactly the
                    // DONE cycle; data_line then holds until the next refill.
                    if (line_full) begin
                        mem_rd     <= 1'b0;
                        data_line  <= line_next;
                        line_valid <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (refill_count != '1) begin
                        refill_count <= refill_count + CNT_W'(1);
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    mem_rd <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_refill_ctrl
//
// Directed bench for icache_refill_ctrl. Two instances share all inputs: one
// with the default 16-bit refill counter and one with a 2-bit counter that
// must saturate at 3. Memory returns word n = 0xA000_0000 + n for byte
// address 4*n. A cycle table covers cold miss, hit and misaligned requests;
// hand-written sequences cover wait states, redirect, reset mid-refill and
// counter saturation.
// -----------------------------------------------------------------------------
module tb_icache_refill_ctrl;
    import icache_refill_ctrl_pkg::*;

    // ---------------- clock / reset / signals ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  fetch_addr;
    logic         req_valid;
    logic         hit;
    logic         mem_ready;
    logic [31:0]  mem_rdata;

    logic         mem_rd,       s_mem_rd;
    logic [31:0]  mem_addr,     s_mem_addr;
    logic [127:0] data_line,    s_data_line;
    logic         line_valid,   s_line_valid;
    logic         stall,        s_stall;
    logic         misalign_err, s_misalign_err;
    logic [15:0]  refill_count;
    logic [1:0]   s_refill_count;
    logic [1:0]   dbg_state,    s_dbg_state;

    always #5 clk = ~clk;

    // Instruction memory model: word index = byte address / 4.
    assign mem_rdata = 32'hA000_0000 + (mem_addr >> 2);

    icache_refill_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_addr   (fetch_addr),
        .req_valid    (req_valid),
        .hit          (hit),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .data_line    (data_line),
        .line_valid   (line_valid),
        .stall        (stall),
        .misalign_err (misalign_err),
        .refill_count (refill_count),
        .dbg_state    (dbg_state)
    );

    icache_refill_ctrl #(.CNT_W(2)) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .fetch_addr   (fetch_addr),
        .req_valid    (req_valid),
        .hit          (hit),
        .mem_rd       (s_mem_rd),
        .mem_addr     (s_mem_addr),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .data_line    (s_data_line),
        .line_valid   (s_line_valid),
        .stall        (s_stall),
        .misalign_err (s_misalign_err),
        .refill_count (s_refill_count),
        .dbg_state    (s_dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    localparam logic [127:0] LINE_40  = 128'hA000_0013_A000_0012_A000_0011_A000_0010;
    localparam logic [127:0] LINE_100 = 128'hA000_0043_A000_0042_A000_0041_A000_0040;
    localparam logic [127:0] LINE_200 = 128'hA000_0083_A000_0082_A000_0081_A000_0080;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic r, input logic rv, input logic h,
                         input logic [31:0] a, input logic rdy);
        @(negedge clk);
        rst        = r;
        req_valid  = rv;
        hit        = h;
        fetch_addr = a;
        mem_ready  = rdy;
        #1;
    endtask

    task automatic check_cycle(input string tag, input logic e_rd, input logic [31:0] e_addr,
                               input logic e_stall, input logic e_lv, input logic [127:0] e_line,
                               input logic e_mis, input logic [15:0] e_cnt, input logic [1:0] e_state);
        logic [15:0] e_sat;
        e_sat = (e_cnt > 16'd3) ? 16'd3 : e_cnt;
        check({tag, " mem_rd"},         mem_rd,         e_rd);
        check({tag, " sat mem_rd"},     s_mem_rd,       e_rd);
        check({tag, " stall"},          stall,          e_stall);
        check({tag, " sat stall"},      s_stall,        e_stall);
        check({tag, " line_valid"},     line_valid,     e_lv);
        check({tag, " sat line_valid"}, s_line_valid,   e_lv);
        check({tag, " misalign_err"},   misalign_err,   e_mis);
        check({tag, " sat misalign"},   s_misalign_err, e_mis);
        check({tag, " refill_count"},   refill_count,   e_cnt);
        check({tag, " sat count"},      s_refill_count, e_sat);
        check({tag, " state"},          dbg_state,      e_state);
        check({tag, " sat state"},      s_dbg_state,    e_state);
        if (e_rd) begin
            check({tag, " mem_addr"},     mem_addr,   e_addr);
            check({tag, " sat mem_addr"}, s_mem_addr, e_addr);
        end
        if (e_lv) begin
            check({tag, " data_line"},     data_line,   e_line);
            check({tag, " sat data_line"}, s_data_line, e_line);
        end
    endtask

    // One full refill with mem_ready tied high; fetch offset 8 inside the line
    // exercises base masking. n is the refill count before this refill.
    task automatic do_refill(input logic [31:0] b, input logic [15:0] n);
        logic [127:0] l;
        string        tag;
        for (int w = 0; w < 4; w++) begin
            l[w*32 +: 32] = 32'hA000_0000 + (b >> 2) + 32'(w);
        end
        tag = $sformatf("refill@%h", b);
        drive(1'b0, 1'b1, 1'b0, b + 32'h8, 1'b1);
        check_cycle({tag, " miss"}, 1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0, n, ST_IDLE);
        for (int w = 0; w < 4; w++) begin
            drive(1'b0, 1'b1, 1'b0, b + 32'h8, 1'b1);
            check_cycle($sformatf("%s beat%0d", tag, w), 1'b1, b + 32'(4 * w),
                        1'b1, 1'b0, '0, 1'b0, n, ST_FETCH);
        end
        drive(1'b0, 1'b1, 1'b0, b + 32'h8, 1'b1);
        check_cycle({tag, " done"}, 1'b0, 32'h0, 1'b1, 1'b1, l, 1'b0, n, ST_DONE);
        drive(1'b0, 1'b1, 1'b1, b + 32'h8, 1'b1);
        check_cycle({tag, " idle"}, 1'b0, 32'h0, 1'b0, 1'b0, '0, 1'b0, n + 16'd1, ST_IDLE);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic         rv;
        logic         h;
        logic         rdy;
        logic [31:0]  addr;
        logic         e_rd;
        logic [31:0]  e_addr;
        logic         e_stall;
        logic         e_lv;
        logic [127:0] e_line;
        logic         e_mis;
        logic [15:0]  e_cnt;
        logic [1:0]   e_state;
    } vec_t;

    function automatic vec_t mk(input logic rv, input logic h, input logic rdy, input logic [31:0] addr,
                                input logic e_rd, input logic [31:0] e_addr, input logic e_stall,
                                input logic e_lv, input logic [127:0] e_line, input logic e_mis,
                                input logic [15:0] e_cnt, input logic [1:0] e_state);
        vec_t v;
        v = '{rv, h, rdy, addr, e_rd, e_addr, e_stall, e_lv, e_line, e_mis, e_cnt, e_state};
        return v;
    endfunction

    vec_t tbl [0:12];

    // ---------------- test sequence ----------------
    initial begin
        // Cold miss at 0x44 (T = row 0), then hit, then misaligned requests.
        tbl[0]  = mk(1, 0, 1, 32'h44,  0, 32'h0,  1, 0, '0,      0, 0, ST_IDLE);
        tbl[1]  = mk(1, 0, 1, 32'h44,  1, 32'h40, 1, 0, '0,      0, 0, ST_FETCH);
        tbl[2]  = mk(1, 0, 1, 32'h44,  1, 32'h44, 1, 0, '0,      0, 0, ST_FETCH);
        tbl[3]  = mk(1, 0, 1, 32'h44,  1, 32'h48, 1, 0, '0,      0, 0, ST_FETCH);
        tbl[4]  = mk(1, 0, 1, 32'h44,  1, 32'h4C, 1, 0, '0,      0, 0, ST_FETCH);
        tbl[5]  = mk(1, 0, 1, 32'h44,  0, 32'h0,  1, 1, LINE_40, 0, 0, ST_DONE);
        tbl[6]  = mk(1, 1, 1, 32'h44,  0, 32'h0,  0, 0, '0,      0, 1, ST_IDLE);
        tbl[7]  = mk(1, 1, 1, 32'h80,  0, 32'h0,  0, 0, '0,      0, 1, ST_IDLE);
        tbl[8]  = mk(1, 1, 0, 32'h80,  0, 32'h0,  0, 0, '0,      0, 1, ST_IDLE);
        tbl[9]  = mk(1, 0, 1, 32'h102, 0, 32'h0,  0, 0, '0,      1, 1, ST_IDLE);
        tbl[10] = mk(1, 0, 0, 32'h102, 0, 32'h0,  0, 0, '0,      1, 1, ST_IDLE);
        tbl[11] = mk(0, 0, 1, 32'h102, 0, 32'h0,  0, 0, '0,      0, 1, ST_IDLE);
        tbl[12] = mk(0, 0, 1, 32'h80,  0, 32'h0,  0, 0, '0,      0, 1, ST_IDLE);

        rst        = 1'b1;
        req_valid  = 1'b0;
        hit        = 1'b0;
        fetch_addr = 32'h0;
        mem_ready  = 1'b0;

        // Reset state.
        @(negedge clk);
        #1;
        check_cycle("reset", 1'b0, 32'h0, 1'b0, 1'b0, '0, 1'b0, 16'd0, ST_IDLE);
        check("reset mem_addr",  mem_addr,  32'h0);
        check("reset data_line", data_line, 128'h0);

        for (int i = 0; i < 13; i++) begin
            drive(1'b0, tbl[i].rv, tbl[i].h, tbl[i].addr, tbl[i].rdy);
            check_cycle($sformatf("vec%0d", i), tbl[i].e_rd, tbl[i].e_addr, tbl[i].e_stall,
                        tbl[i].e_lv, tbl[i].e_line, tbl[i].e_mis, tbl[i].e_cnt, tbl[i].e_state);
        end

        // Wait states: mem_ready low for 3 cycles before beat 2.
        drive(0, 1, 0, 32'h40, 1); check_cycle("ws miss",  0, 32'h0,  1, 0, '0, 0, 1, ST_IDLE);
        drive(0, 1, 0, 32'h40, 1); check_cycle("ws beat0", 1, 32'h40, 1, 0, '0, 0, 1, ST_FETCH);
        drive(0, 1, 0, 32'h40, 1); check_cycle("ws beat1", 1, 32'h44, 1, 0, '0, 0, 1, ST_FETCH);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 32'h40, 0);
            check_cycle($sformatf("ws hold%0d", k), 1, 32'h48, 1, 0, '0, 0, 1, ST_FETCH);
        end
        drive(0, 1, 0, 32'h40, 1); check_cycle("ws beat2", 1, 32'h48, 1, 0, '0, 0, 1, ST_FETCH);
        drive(0, 1, 0, 32'h40, 1); check_cycle("ws beat3", 1, 32'h4C, 1, 0, '0, 0, 1, ST_FETCH);
        drive(0, 1, 0, 32'h40, 1); check_cycle("ws done",  0, 32'h0,  1, 1, LINE_40, 0, 1, ST_DONE);
        drive(0, 1, 1, 32'h40, 1); check_cycle("ws idle",  0, 32'h0,  0, 0, '0, 0, 2, ST_IDLE);

        // Redirect 0x100 -> 0x200 during beat 1: the 0x100 line completes first.
        drive(0, 1, 0, 32'h100, 1); check_cycle("rd miss",  0, 32'h0,   1, 0, '0, 0, 2, ST_IDLE);
        drive(0, 1, 0, 32'h100, 1); check_cycle("rd beat0", 1, 32'h100, 1, 0, '0, 0, 2, ST_FETCH);
        drive(0, 1, 0, 32'h200, 1); check_cycle("rd beat1", 1, 32'h104, 1, 0, '0, 0, 2, ST_FETCH);
        drive(0, 1, 0, 32'h200, 1); check_cycle("rd beat2", 1, 32'h108, 1, 0, '0, 0, 2, ST_FETCH);
        drive(0, 1, 0, 32'h200, 1); check_cycle("rd beat3", 1, 32'h10C, 1, 0, '0, 0, 2, ST_FETCH);
        drive(0, 1, 0, 32'h200, 1); check_cycle("rd done",  0, 32'h0,   1, 1, LINE_100, 0, 2, ST_DONE);
        drive(0, 1, 0, 32'h200, 1); check_cycle("rd miss2", 0, 32'h0,   1, 0, '0, 0, 3, ST_IDLE);
        check("rd line held", data_line, LINE_100);
        drive(0, 1, 0, 32'h200, 1); check_cycle("rd2 beat0", 1, 32'h200, 1, 0, '0, 0, 3, ST_FETCH);
        drive(0, 1, 0, 32'h200, 1); check_cycle("rd2 beat1", 1, 32'h204, 1, 0, '0, 0, 3, ST_FETCH);
        drive(0, 1, 0, 32'h200, 1); check_cycle("rd2 beat2", 1, 32'h208, 1, 0, '0, 0, 3, ST_FETCH);
        drive(0, 1, 0, 32'h200, 1); check_cycle("rd2 beat3", 1, 32'h20C, 1, 0, '0, 0, 3, ST_FETCH);
        drive(0, 1, 0, 32'h200, 1); check_cycle("rd2 done",  0, 32'h0,   1, 1, LINE_200, 0, 3, ST_DONE);
        drive(0, 1, 1, 32'h200, 1); check_cycle("rd2 idle",  0, 32'h0,   0, 0, '0, 0, 4, ST_IDLE);

        // Reset mid-FETCH after 2 beats, with mem_ready high in the reset cycle.
        drive(0, 1, 0, 32'h40, 1); check_cycle("rst miss",  0, 32'h0,  1, 0, '0, 0, 4, ST_IDLE);
        drive(0, 1, 0, 32'h40, 1); check_cycle("rst beat0", 1, 32'h40, 1, 0, '0, 0, 4, ST_FETCH);
        drive(0, 1, 0, 32'h40, 1); check_cycle("rst beat1", 1, 32'h44, 1, 0, '0, 0, 4, ST_FETCH);
        drive(1, 1, 0, 32'h40, 1); check_cycle("rst async", 0, 32'h0,  0, 0, '0, 0, 0, ST_IDLE);
        check("rst mem_addr",  mem_addr,  32'h0);
        check("rst data_line", data_line, 128'h0);
        drive(1, 1, 0, 32'h102, 1); check_cycle("rst hold", 0, 32'h0, 0, 0, '0, 0, 0, ST_IDLE);
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 32'h40, 1);
            check_cycle($sformatf("post rst%0d", k), 0, 32'h0, 0, 0, '0, 0, 0, ST_IDLE);
        end

        // Five refills: 16-bit counter reaches 5, 2-bit counter stops at 3.
        for (int i = 0; i < 5; i++) begin
            do_refill(32'h0000_0300 + 32'(16 * i), 16'(i));
        end
        check("final refill_count", refill_count, 16'd5);
        check("final sat count",    s_refill_count, 2'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
